fetch_unit: RTL and testbench

Instruction fetch stage sitting directly upstream of `decode`. It owns the program counter and issues word-aligned read requests to instruction memory over a valid/ready request channel. In-order responses are collected into a 2-entry instruction buffer, and `inst_encoding` / `inst_pc` are presented to decode with a valid/ready handshake. A redirect input (JAL/branch target from later stages) flushes the buffer and discards in-flight responses.

---
 rtl/fetch_unit_pkg.sv | 19 +
 rtl/fetch_buffer.sv | 75 +++++++
 rtl/fetch_unit.sv | 95 +++++++++
 tb/tb_fetch_unit.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_unit_pkg.sv
// Shared constants, slot type and helpers for the instruction fetch stage.
package fetch_unit_pkg;

    localparam logic [31:0] INST_NOP        = 32'h0000_0013;
    localparam int          FETCH_BUF_DEPTH = 2;

    // One instruction buffer entry: allocated at request accept, filled at response.
    typedef struct packed {
        logic        used;
        logic        filled;
        logic [31:0] pc;
        logic [31:0] data;
    } fetch_slot_t;

    function automatic logic [31:0] align_word(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_buffer.sv
// Two-entry in-order instruction buffer. Slots are allocated when a request is
// accepted, filled by responses in the same order, and read out from the head.
module fetch_buffer
    import fetch_unit_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        alloc,
    input  logic [31:0] alloc_pc,
    input  logic        fill,
    input  logic [31:0] fill_data,
    input  logic        pop,
    input  logic        flush,
    output logic        head_valid,
    output logic [31:0] head_pc,
    output logic [31:0] head_data,
    output logic [1:0]  occupancy
);

    fetch_slot_t slots [FETCH_BUF_DEPTH];
    logic        alloc_ptr;
    logic        fill_ptr;
    logic        rd_ptr;
    logic [1:0]  count;
    logic        pop_ok;
    logic        fill_ok;

    assign head_valid = slots[rd_ptr].used && slots[rd_ptr].filled;
    assign head_pc    = slots[rd_ptr].pc;
    assign head_data  = slots[rd_ptr].data;
    assign occupancy  = count;
    assign pop_ok     = pop && head_valid;
    // A fill only lands on an allocated slot that is still waiting for data.
    assign fill_ok    = fill && slots[fill_ptr].used && !slots[fill_ptr].filled;

    // Ring update. When full, a pop and an alloc hit the same slot; the alloc
    // is written last so it wins.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < FETCH_BUF_DEPTH; i++) begin
                slots[i] <= '0;
            end
            alloc_ptr <= 1'b0;
            fill_ptr  <= 1'b0;
            rd_ptr    <= 1'b0;
            count     <= 2'd0;
        end else if (flush) begin
            for (int i = 0; i < FETCH_BUF_DEPTH; i++) begin
                slots[i].used   <= 1'b0;
                slots[i].filled <= 1'b0;
            end
            alloc_ptr <= 1'b0;
            fill_ptr  <= 1'b0;
            rd_ptr    <= 1'b0;
            count     <= 2'd0;
        end else begin
            if (pop_ok) begin
                slots[rd_ptr].used   <= 1'b0;
                slots[rd_ptr].filled <= 1'b0;
                rd_ptr               <= ~rd_ptr;
            end
            if (fill_ok) begin
                slots[fill_ptr].filled <= 1'b1;
                slots[fill_ptr].data   <= fill_data;
                fill_ptr               <= ~fill_ptr;
            end
            if (alloc) begin
                slots[alloc_ptr] <= '{used: 1'b1, filled: 1'b0, pc: alloc_pc, data: 32'h0};
                alloc_ptr        <= ~alloc_ptr;
            end
            count <= count + {1'b0, alloc} - {1'b0, pop_ok};
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues word-aligned reads, tracks
// in-flight responses and discards the stale ones left behind by a redirect.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst_encoding,
    output logic [31:0] inst_pc
);

    localparam logic [31:0] START_PC = align_word(RESET_PC);

    logic [31:0] pc;
    logic [1:0]  outstanding;
    logic [1:0]  outstanding_next;
    logic [1:0]  drop_cnt;
    logic [1:0]  occupancy;
    logic [2:0]  committed;
    logic        head_valid;
    logic [31:0] head_pc;
    logic [31:0] head_data;
    logic        pop;
    logic        req_accept;
    logic        resp_take;
    logic        fill;

    assign pop = head_valid && inst_ready;

    // A slot popped this cycle counts as free, so a one-cycle memory keeps a
    // steady one instruction per cycle. Stale in-flight reads still hold space.
    assign committed      = {1'b0, occupancy} + {1'b0, drop_cnt} - {2'b00, pop};
    assign imem_req_valid = !rst && (committed < 3'd2);
    assign imem_req_addr  = pc;
    assign req_accept     = imem_req_valid && imem_req_ready;

    // Responses with nothing outstanding are protocol errors and are ignored.
    assign resp_take        = imem_resp_valid && (outstanding != 2'd0);
    assign fill             = resp_take && (drop_cnt == 2'd0);
    assign outstanding_next = outstanding + {1'b0, req_accept} - {1'b0, resp_take};

    assign inst_valid    = head_valid;
    assign inst_encoding = head_valid ? head_data : INST_NOP;
    assign inst_pc       = head_valid ? head_pc : 32'h0;

    fetch_buffer u_buffer (
        .clk        (clk),
        .rst        (rst),
        .alloc      (req_accept),
        .alloc_pc   (pc),
        .fill       (fill),
        .fill_data  (imem_resp_data),
        .pop        (pop),
        .flush      (redirect_valid),
        .head_valid (head_valid),
        .head_pc    (head_pc),
        .head_data  (head_data),
        .occupancy  (occupancy)
    );

    // PC, in-flight count and drop count; a redirect turns every read still in
    // flight after this cycle into one to be discarded.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc          <= START_PC;
            outstanding <= 2'd0;
            drop_cnt    <= 2'd0;
        end else begin
            outstanding <= outstanding_next;
            if (redirect_valid) begin
                pc       <= align_word(redirect_pc);
                drop_cnt <= outstanding_next;
            end else begin
                if (req_accept) begin
                    pc <= pc + 32'd4;
                end
                if (resp_take && (drop_cnt != 2'd0)) begin
                    drop_cnt <= drop_cnt - 2'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus a randomized run,
// all checked every cycle against a queue-based model of the fetch stream.
module tb_fetch_unit;

    localparam logic [31:0] RST_PC = 32'h0000_0000;
    localparam logic [31:0] NOP    = 32'h0000_0013;
    localparam logic [31:0] XOR_K  = 32'hA5A5_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst_encoding;
    logic [31:0] inst_pc;

    always #5 clk = ~clk;

    fetch_unit #(.RESET_PC(RST_PC)) dut (
        .clk             (clk),
        .rst             (rst),
        .imem_req_valid  (imem_req_valid),
        .imem_req_ready  (imem_req_ready),
        .imem_req_addr   (imem_req_addr),
        .imem_resp_valid (imem_resp_valid),
        .imem_resp_data  (imem_resp_data),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc),
        .inst_valid      (inst_valid),
        .inst_ready      (inst_ready),
        .inst_encoding   (inst_encoding),
        .inst_pc         (inst_pc)
    );

    // Reference: fetches that decode should still see, in program order.
    typedef struct { logic [31:0] pc; bit filled; } exp_t;
    // Memory environment: reads in flight, stale ones were overtaken by a redirect.
    typedef struct { logic [31:0] data; int due; bit stale; } pend_t;

    exp_t        exp_q[$];
    pend_t       pend_q[$];
    logic [31:0] model_pc;
    int          cyc;
    int          last_due;
    int          mem_lat;
    int          checks;
    int          failures;
    bit          last_acc;
    bit          last_pop;
    logic [31:0] last_acc_addr;
    logic [31:0] last_pop_pc;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        pend_q.delete();
        model_pc = RST_PC;
        last_due = -1;
    endtask

    task automatic idle_inputs();
        imem_req_ready  = 1'b0;
        inst_ready      = 1'b0;
        redirect_valid  = 1'b0;
        redirect_pc     = 32'h0;
        imem_resp_valid = 1'b0;
        imem_resp_data  = 32'h0;
    endtask

    // One clock: drive, check against the model, clock, advance the model.
    task automatic step(input bit rdy, input bit irdy, input bit redir,
                        input logic [31:0] rpc, input bit spur);
        bit          resp_now;
        bit          exp_iv;
        bit          exp_rv;
        bit          pop_now;
        bit          act_acc;
        bit          done;
        int          stale;
        int          live_n;
        int          d;
        logic [31:0] exp_ipc;
        logic [31:0] acc_addr;
        pend_t       p;
        @(negedge clk);
        resp_now        = (pend_q.size() > 0) && (pend_q[0].due <= cyc);
        imem_req_ready  = rdy;
        inst_ready      = irdy;
        redirect_valid  = redir;
        redirect_pc     = rpc;
        imem_resp_valid = resp_now || (spur && (pend_q.size() == 0));
        imem_resp_data  = resp_now ? pend_q[0].data : $urandom;
        #1;
        stale = 0;
        foreach (pend_q[i]) if (pend_q[i].stale) stale++;
        exp_iv  = (exp_q.size() > 0) && exp_q[0].filled;
        pop_now = exp_iv && irdy;
        live_n  = exp_q.size() - (pop_now ? 1 : 0);
        exp_rv  = (live_n + stale) < 2;
        exp_ipc = exp_iv ? exp_q[0].pc : 32'h0;
        check_val("req_valid", imem_req_valid, exp_rv);
        if (exp_rv) check_val("req_addr", imem_req_addr, model_pc);
        check_val("inst_valid", inst_valid, exp_iv);
        check_val("inst_pc", inst_pc, exp_ipc);
        check_val("inst_enc", inst_encoding, exp_iv ? (exp_ipc ^ XOR_K) : NOP);
        act_acc       = imem_req_valid && rdy;
        acc_addr      = imem_req_addr;
        last_acc      = act_acc;
        last_acc_addr = acc_addr;
        last_pop      = inst_valid && irdy;
        last_pop_pc   = inst_pc;
        @(posedge clk);
        if (pop_now) void'(exp_q.pop_front());
        if (resp_now) begin
            p = pend_q.pop_front();
            if (!p.stale) begin
                done = 1'b0;
                foreach (exp_q[i]) begin
                    if (!done && !exp_q[i].filled) begin
                        exp_q[i].filled = 1'b1;
                        done = 1'b1;
                    end
                end
            end
        end
        if (exp_rv && rdy) begin
            exp_q.push_back('{pc: model_pc, filled: 1'b0});
            model_pc = model_pc + 32'd4;
        end
        if (act_acc) begin
            d = (cyc + mem_lat > last_due + 1) ? cyc + mem_lat : last_due + 1;
            pend_q.push_back('{data: acc_addr ^ XOR_K, due: d, stale: 1'b0});
            last_due = d;
        end
        if (redir) begin
            exp_q.delete();
            foreach (pend_q[i]) pend_q[i].stale = 1'b1;
            model_pc = rpc & 32'hFFFF_FFFC;
        end
        cyc++;
        #1 idle_inputs();
    endtask

    // Asynchronous reset between edges; memory is reset alongside.
    task automatic do_reset();
        @(posedge clk);
        #2 rst = 1'b1;
        idle_inputs();
        #1;
        check_val("rst_req_valid", imem_req_valid, 1'b0);
        check_val("rst_req_addr", imem_req_addr, RST_PC);
        check_val("rst_inst_valid", inst_valid, 1'b0);
        check_val("rst_inst_enc", inst_encoding, NOP);
        check_val("rst_inst_pc", inst_pc, 32'h0);
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_val("post_rst_req_valid", imem_req_valid, 1'b1);
        check_val("post_rst_req_addr", imem_req_addr, RST_PC);
    endtask

    initial begin
        int          pops;
        int          accs;
        int          n;
        logic [31:0] got_a [2];
        logic [31:0] got_p [2];
        rst      = 1'b1;
        checks   = 0;
        failures = 0;
        cyc      = 0;
        mem_lat  = 1;
        idle_inputs();
        model_reset();

        // Streaming with a one-cycle memory.
        do_reset();
        pops = 0;
        for (int i = 0; i < 30; i++) begin
            step(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
            if (i >= 10 && last_pop) pops++;
        end
        check_val("throughput", pops, 32'd20);

        // Decode stalled: two requests fill the buffer, then issue stops.
        do_reset();
        accs = 0;
        for (int i = 0; i < 10; i++) begin
            step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
            if (last_acc) accs++;
        end
        check_val("stall_accepts", accs, 32'd2);
        check_val("stall_req_valid", imem_req_valid, 1'b0);
        got_p[0] = 32'hDEAD_BEEF;
        got_p[1] = 32'hDEAD_BEEF;
        n = 0;
        for (int i = 0; i < 10 && n < 2; i++) begin
            step(1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
            if (last_pop) begin got_p[n] = last_pop_pc; n++; end
        end
        check_val("stall_pop0", got_p[0], 32'h0);
        check_val("stall_pop1", got_p[1], 32'h4);

        // Redirect with two reads in flight on a three-cycle memory.
        do_reset();
        mem_lat = 3;
        step(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
        step(1'b1, 1'b1, 1'b1, 32'h0000_0102, 1'b0);
        got_a[0] = 32'hDEAD_BEEF;
        got_p[0] = 32'hDEAD_BEEF;
        for (int i = 0; i < 25; i++) begin
            step(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
            if (last_acc && got_a[0] == 32'hDEAD_BEEF) got_a[0] = last_acc_addr;
            if (last_pop && got_p[0] == 32'hDEAD_BEEF) got_p[0] = last_pop_pc;
        end
        check_val("redir_first_req", got_a[0], 32'h0000_0100);
        check_val("redir_first_pop", got_p[0], 32'h0000_0100);

        // Redirect coinciding with a response and a request accept.
        do_reset();
        mem_lat = 1;
        step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
        step(1'b1, 1'b0, 1'b1, 32'h0000_0200, 1'b0);
        check_val("coinc_accept", last_acc, 1'b1);
        got_p[0] = 32'hDEAD_BEEF;
        for (int i = 0; i < 20; i++) begin
            step(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
            if (last_pop && got_p[0] == 32'hDEAD_BEEF) got_p[0] = last_pop_pc;
        end
        check_val("coinc_first_pop", got_p[0], 32'h0000_0200);

        // PC wrap at the top of the address space (low redirect bits ignored).
        do_reset();
        step(1'b1, 1'b1, 1'b1, 32'hFFFF_FFFE, 1'b0);
        got_a[0] = 32'hDEAD_BEEF;
        got_a[1] = 32'hDEAD_BEEF;
        n = 0;
        for (int i = 0; i < 20; i++) begin
            step(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
            if (last_acc && n < 2) begin got_a[n] = last_acc_addr; n++; end
        end
        check_val("wrap_req0", got_a[0], 32'hFFFF_FFFC);
        check_val("wrap_req1", got_a[1], 32'h0000_0000);

        // Reset with two reads outstanding.
        do_reset();
        mem_lat = 3;
        step(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
        do_reset();
        step(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
        check_val("post_rst_first_acc", last_acc, 1'b1);
        check_val("post_rst_first_addr", last_acc_addr, RST_PC);

        // Randomized traffic: latency, back-pressure, redirects, stray responses.
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            if (i % 200 == 0) mem_lat = int'($urandom_range(1, 4));
            if (i % 700 == 699) do_reset();
            step($urandom_range(0, 3) != 0, $urandom_range(0, 9) < 7,
                 $urandom_range(0, 19) == 0, $urandom, $urandom_range(0, 7) == 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
